cpu_core: RTL and testbench
===========================

# cpu_core

Parametrised, multi-cycle successor to the single-cycle `cpu` datapath. It executes one 3-operand-field instruction at a time over a valid/ready handshake. It holds a resettable register file and a synchronous data RAM, and writes ALU results back to the destination register. It adds registered status flags, real load/store sequencing and the previously unimplemented opcodes.

## Interface
Parameters:
- `WIDTH`, 16: datapath, register and memory word width, ≥4.
- `NREGS`, 8: register count, a power of two ≥2. `RAW = $clog2(NREGS)`.
- `MEM_DEPTH`, 1024: data RAM words, a power of two ≥2. `MAW = $clog2(MEM_DEPTH)`.

Ports:
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: core idle; instruction accepted when `in_valid && in_ready`.
- `op` in 4: opcode.
- `op1` in RAW: destination / operand-A register address.
- `op2` in RAW: operand-B register address.
- `out_valid` out 1: result available; held until accepted.
- `out_ready` in 1: result consumed when `out_valid && out_ready`.
- `y` out WIDTH: result.
- `c`, `v`, `z` out 1 each: carry/borrow, signed overflow, zero.

## Operation
- A = reg[op1], B = reg[op2], both captured at accept. Memory address = B[MAW-1:0]; upper bits ignored, so addresses wrap.
- Opcodes:
  - 0000 INC: A+1.
  - 0001 DEC: A−1.
  - 0010 SUB: A−B.
  - 0011 ADD: A+B.
  - 0100 SHL: A<<1; c = A[MSB].
  - 0101 STORE: mem[addr]=A; y=A; no register write.
  - 0110 LOAD: reg[op1]=mem[addr]; y = loaded word.
  - 0111 LAND: y = {0…,(A≠0)&&(B≠0)}.
  - 1000 LOR: y = {0…,(A≠0)||(B≠0)}.
  - 1001 AND, 1010 OR, 1011 XNOR: bitwise.
  - 1100 MOV: y=B.
  - 1101 SHR: logical A>>1; c = A[0].
  - 1110, 1111 NOP.
- Register write-back of y to reg[op1]: all opcodes except STORE and NOP.
- Arithmetic is modulo 2^WIDTH. For SUB/DEC, c = borrow (= NOT carry-out). v = carry into MSB XOR carry out of MSB. For ops other than INC/DEC/SUB/ADD/SHL/SHR, c=0 and v=0; for SHL/SHR, v=0.
- z = (y==0) for every opcode except NOP.
- NOP: y, c, v, z keep their previous values; `out_valid` still produced.
- Reset:
  - State → IDLE.
  - reg[i] = i mod 2^WIDTH.
  - y=0, c=v=0, z=1, out_valid=0, in_ready=1.
  - RAM contents are not reset; the simulation initialiser sets mem[i] = i mod 2^WIDTH.

## Timing
- FSM states: IDLE, EXEC, MEM, RESP.
- IDLE: in_ready=1. On accept, latch op/op1/op2 → EXEC.
- EXEC: read operands and compute.
  - ALU/MOV/NOP: register y/flags and perform write-back at this edge → RESP.
  - STORE: RAM write at this edge → RESP.
  - LOAD: issue synchronous read → MEM.
- MEM: RAM data valid; write reg[op1], y and flags → RESP.
- RESP: out_valid=1 with y/c/v/z stable. On out_ready → IDLE. Otherwise hold indefinitely.
- Latency from the accept edge (cycle 0): out_valid rises in cycle 2 for non-LOAD ops and cycle 3 for LOAD.
- Maximum throughput is one instruction per 3 cycles (4 for LOAD) with out_ready tied high.
- in_ready=0 in EXEC/MEM/RESP. in_valid is ignored there and instruction fields are not sampled.
- op1==op2 on LOAD: the address is taken from the pre-write value.
- The next instruction sees all prior write-backs (strictly serialised, no hazards).
- Reset asserted mid-instruction: immediate return to the reset values.
  - The in-flight instruction is dropped.
  - Any register or RAM write not yet clocked does not occur.
- y and flags change only on EXEC/MEM completion edges, never in RESP or IDLE.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams/enum (OP_INC … OP_NOP1);
  - FSM state enum;
  - flag struct {c,v,z}.
- One combinational sub-module, `cpu_alu` (parametrised by WIDTH): takes op, A, B and returns result, c, v.
- Register file, RAM and FSM are inline in `cpu_core`.

## Test plan
- Reset, then ADD op1=1 op2=2 with out_ready=1 → out_valid in cycle 2; y=3, c=0, v=0, z=0; a following MOV op1=0 op2=1 returns y=3.
- SUB op1=0 op2=1 → y=0xFFFF, c=1, v=0, z=0. Then DEC op1=1 → y=0, z=1, c=0.
- LOAD op1=3 op2=5 → out_valid in cycle 3, y=5. STORE op1=2 op2=4 → mem[4]=2. Then LOAD op1=6 op2=4 → y=2, reg6=2.
- out_ready low for 5 cycles in RESP → y and flags stable, in_ready=0, and a concurrent in_valid with ADD is not accepted or executed.
- WIDTH=4 instance: ADD op1=7 op2=1 → y=0x8, v=1, c=0. SHL on reg7 → y=0xE, c=0.
- rst_n pulsed low during the MEM state of a LOAD → out_valid=0, y=0, z=1, and reg[op1] keeps its reset value.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode, FSM-state and flag definitions for the multi-cycle cpu_core.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_INC   = 4'h0,
    OP_DEC   = 4'h1,
    OP_SUB   = 4'h2,
    OP_ADD   = 4'h3,
    OP_SHL   = 4'h4,
    OP_STORE = 4'h5,
    OP_LOAD  = 4'h6,
    OP_LAND  = 4'h7,
    OP_LOR   = 4'h8,
    OP_AND   = 4'h9,
    OP_OR    = 4'ha,
    OP_XNOR  = 4'hb,
    OP_MOV   = 4'hc,
    OP_SHR   = 4'hd,
    OP_NOP0  = 4'he,
    OP_NOP1  = 4'hf
  } op_e;

  typedef enum logic [1:0] {StIdle, StExec, StMem, StResp} state_e;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
  } flags_t;

  function automatic logic is_nop(op_e o);
    return o inside {OP_NOP0, OP_NOP1};
  endfunction

  function automatic logic writes_reg(op_e o);
    return !(o inside {OP_STORE, OP_NOP0, OP_NOP1});
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: one shared adder serves INC/DEC/SUB/ADD; c is borrow for DEC/SUB.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             v
);

  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] low;
  logic             carry_msb;

  always_comb begin
    add_b   = b;
    add_cin = 1'b0;
    unique case (op)
      OP_INC:  add_b = WIDTH'(1);
      OP_DEC:  begin add_b = ~WIDTH'(1); add_cin = 1'b1; end
      OP_SUB:  begin add_b = ~b;         add_cin = 1'b1; end
      default: ;
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  // Carry into the MSB, for the signed-overflow flag.
  assign low = {1'b0, a[WIDTH-2:0]} + {1'b0, add_b[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, add_cin};
  assign carry_msb = low[WIDTH-1];

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    unique case (op)
      OP_INC, OP_ADD: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = carry_msb ^ sum[WIDTH];
      end
      OP_DEC, OP_SUB: begin
        result = sum[WIDTH-1:0];
        c      = ~sum[WIDTH];
        v      = carry_msb ^ sum[WIDTH];
      end
      OP_SHL:   begin result = {a[WIDTH-2:0], 1'b0}; c = a[WIDTH-1]; end
      OP_SHR:   begin result = {1'b0, a[WIDTH-1:1]}; c = a[0]; end
      OP_STORE: result = a;
      OP_LAND:  result = {{(WIDTH-1){1'b0}}, (|a) & (|b)};
      OP_LOR:   result = {{(WIDTH-1){1'b0}}, (|a) | (|b)};
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XNOR:  result = ~(a ^ b);
      OP_MOV:   result = b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle core: one instruction at a time over valid/ready, with register file,
// synchronous data RAM and registered result/flags.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NREGS     = 8,
  parameter int unsigned MEM_DEPTH = 1024,
  localparam int unsigned RAW      = $clog2(NREGS),
  localparam int unsigned MAW      = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [RAW-1:0]   op1,
  input  logic [RAW-1:0]   op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             v,
  output logic             z
);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [RAW-1:0]   op1_q, op2_q;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] y_q;
  flags_t           flags_q;

  logic [WIDTH-1:0] a, b, alu_y;
  logic [MAW-1:0]   addr;
  logic             alu_c, alu_v;

  assign a    = rf_q[op1_q];
  assign b    = rf_q[op2_q];
  assign addr = b[MAW-1:0];

  cpu_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (op_q),
    .a      (a),
    .b      (b),
    .result (alu_y),
    .c      (alu_c),
    .v      (alu_v)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StExec;
      StExec:  state_d = (op_q == OP_LOAD) ? StMem : StResp;
      StMem:   state_d = StResp;
      StResp:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OP_NOP0;
      op1_q   <= '0;
      op2_q   <= '0;
      y_q     <= '0;
      flags_q <= '{c: 1'b0, v: 1'b0, z: 1'b1};
      for (int i = 0; i < NREGS; i++) rf_q[i] <= WIDTH'(i);
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && in_valid) begin
        op_q  <= op_e'(op);
        op1_q <= op1;
        op2_q <= op2;
      end
      if (state_q == StExec && op_q != OP_LOAD && !is_nop(op_q)) begin
        y_q     <= alu_y;
        flags_q <= '{c: alu_c, v: alu_v, z: (alu_y == '0)};
        if (writes_reg(op_q)) rf_q[op1_q] <= alu_y;
      end
      if (state_q == StMem) begin
        y_q          <= rdata_q;
        flags_q      <= '{c: 1'b0, v: 1'b0, z: (rdata_q == '0)};
        rf_q[op1_q]  <= rdata_q;
      end
    end
  end

  // RAM is not reset; writes are gated by EXEC, which reset leaves immediately.
  always_ff @(posedge clk) begin
    if (state_q == StExec) begin
      if (op_q == OP_STORE) mem_q[addr] <= a;
      rdata_q <= mem_q[addr];
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StResp);
  assign y         = y_q;
  assign c         = flags_q.c;
  assign v         = flags_q.v;
  assign z         = flags_q.z;

endmodule

// File: tb/tb_cpu_core.sv
// Randomised bench for cpu_core with a behavioural model and a per-cycle response checker.
module tb_cpu_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main 16-bit instance.
  logic        rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [2:0]  op1 = 3'd0, op2 = 3'd0;
  logic        in_ready, out_valid, c, v, z;
  logic [15:0] y;

  cpu_core #(.WIDTH(16), .NREGS(8), .MEM_DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .op1(op1),
    .op2(op2), .out_valid(out_valid), .out_ready(out_ready), .y(y), .c(c), .v(v), .z(z)
  );

  // Narrow 4-bit instance for overflow boundaries.
  logic       s_rst_n = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b1;
  logic [3:0] s_op = 4'd0;
  logic [2:0] s_op1 = 3'd0, s_op2 = 3'd0;
  logic       s_in_ready, s_out_valid, s_c, s_v, s_z;
  logic [3:0] s_y;

  cpu_core #(.WIDTH(4), .NREGS(8), .MEM_DEPTH(16)) dut4 (
    .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
    .op1(s_op1), .op2(s_op2), .out_valid(s_out_valid), .out_ready(s_out_ready), .y(s_y),
    .c(s_c), .v(s_v), .z(s_z)
  );

  int errors = 0;
  int checks = 0;

  int mregs [8];
  int mmem  [1024];
  logic [15:0] exp_y;
  logic        exp_c, exp_v, exp_z;
  bit          cmp_en = 1'b0;
  logic [15:0] got_y;
  logic [2:0]  got_f;
  logic [3:0]  got4_y;
  logic [2:0]  got4_f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int s16(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = i;
    exp_y = 16'h0; exp_c = 1'b0; exp_v = 1'b0; exp_z = 1'b1;
  endtask

  task automatic model_exec(input logic [3:0] o, input int r1, input int r2);
    int a, b, r, sr;
    bit wr;
    a = mregs[r1]; b = mregs[r2]; r = 0; sr = 0; wr = 1'b1;
    if (o >= 4'd14) return;
    exp_c = 1'b0; exp_v = 1'b0;
    case (o)
      4'd0:  begin r = a + 1; exp_c = (a == 65535); exp_v = (a == 32767); end
      4'd1:  begin r = a - 1; exp_c = (a == 0); exp_v = (a == 32768); end
      4'd2:  begin
        r = a - b; exp_c = (a < b); sr = s16(a) - s16(b);
        exp_v = (sr > 32767) || (sr < -32768);
      end
      4'd3:  begin
        r = a + b; exp_c = (r > 65535); sr = s16(a) + s16(b);
        exp_v = (sr > 32767) || (sr < -32768);
      end
      4'd4:  begin r = a * 2; exp_c = (a >= 32768); end
      4'd5:  begin r = a; mmem[b % 1024] = a; wr = 1'b0; end
      4'd6:  r = mmem[b % 1024];
      4'd7:  r = (a != 0 && b != 0) ? 1 : 0;
      4'd8:  r = (a != 0 || b != 0) ? 1 : 0;
      4'd9:  r = a & b;
      4'd10: r = a | b;
      4'd11: r = ~(a ^ b);
      4'd12: r = b;
      4'd13: begin r = a / 2; exp_c = (a % 2 == 1); end
      default: ;
    endcase
    r = r & 65535;
    exp_y = 16'(r);
    exp_z = (r == 0);
    if (wr) mregs[r1] = r;
  endtask

  // Every response cycle must match the model and keep the core busy.
  always @(negedge clk) begin
    if (cmp_en && rst_n && out_valid) begin
      chk("resp_y", 32'(y), 32'(exp_y));
      chk("resp_cvz", {29'b0, c, v, z}, {29'b0, exp_c, exp_v, exp_z});
      chk("resp_in_ready", 32'(in_ready), 32'd0);
    end
  end

  // Offers a competing ADD while the core is busy; it must be ignored.
  task automatic junk();
    in_valid = 1'b1;
    op  = 4'd3;
    op1 = 3'($urandom_range(0, 7));
    op2 = 3'($urandom_range(0, 7));
  endtask

  task automatic issue(input logic [3:0] o, input int r1, input int r2, input int hold);
    int cyc;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; op1 = 3'(r1); op2 = 3'(r2); out_ready = (hold == 0);
    @(posedge clk); #1;
    model_exec(o, r1, r2);
    cmp_en = 1'b1;
    cyc = 1;
    while (cyc <= 8) begin
      @(negedge clk);
      if (out_valid) break;
      junk();
      cyc++;
    end
    chk("latency", 32'(cyc), (o == 4'd6) ? 32'd3 : 32'd2);
    got_y = y; got_f = {c, v, z};
    for (int i = 0; i < hold; i++) begin
      junk();
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cmp_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_cvz", {29'b0, c, v, z}, 32'b001);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic issue4(input logic [3:0] o, input int r1, input int r2);
    int cyc;
    @(negedge clk);
    s_in_valid = 1'b1; s_op = o; s_op1 = 3'(r1); s_op2 = 3'(r2);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    cyc = 1;
    while (cyc <= 8) begin
      @(negedge clk);
      if (s_out_valid) break;
      cyc++;
    end
    chk("w4_latency", 32'(cyc), 32'd2);
    got4_y = s_y; got4_f = {s_c, s_v, s_z};
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mmem[i] = i;
      dut.mem_q[i] = 16'(i);
    end
    for (int i = 0; i < 16; i++) dut4.mem_q[i] = 4'(i);
    model_reset();
    repeat (2) @(negedge clk);

    // ADD then MOV from reset.
    do_reset();
    issue(4'd3, 1, 2, 0);
    chk("add_y", 32'(got_y), 32'd3);
    chk("add_cvz", 32'(got_f), 32'b000);
    issue(4'd12, 0, 1, 0);
    chk("mov_y", 32'(got_y), 32'd3);

    // Borrow and zero.
    do_reset();
    issue(4'd2, 0, 1, 0);
    chk("sub_y", 32'(got_y), 32'hffff);
    chk("sub_cvz", 32'(got_f), 32'b100);
    issue(4'd1, 1, 0, 0);
    chk("dec_y", 32'(got_y), 32'd0);
    chk("dec_cvz", 32'(got_f), 32'b001);

    // Memory sequencing.
    issue(4'd6, 3, 5, 0);
    chk("load_y", 32'(got_y), 32'd5);
    issue(4'd5, 2, 4, 0);
    chk("store_y", 32'(got_y), 32'd2);
    issue(4'd6, 6, 4, 0);
    chk("load_stored_y", 32'(got_y), 32'd2);
    issue(4'd12, 0, 6, 0);
    chk("reg6_y", 32'(got_y), 32'd2);

    // Backpressure: held response, competing ADD must not run.
    issue(4'd3, 2, 2, 5);
    chk("hold_add_y", 32'(got_y), 32'd4);
    issue(4'd12, 0, 2, 0);
    chk("hold_once_y", 32'(got_y), 32'd4);

    // Reset during MEM of a LOAD.
    @(negedge clk);
    cmp_en = 1'b0; in_valid = 1'b1; op = 4'd6; op1 = 3'd3; op2 = 3'd5; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mem_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_y", 32'(y), 32'd0);
    chk("midrst_z", 32'(z), 32'd1);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    issue(4'd12, 0, 3, 0);
    chk("midrst_reg3", 32'(got_y), 32'd3);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      issue(4'($urandom_range(0, 15)), $urandom_range(0, 7), $urandom_range(0, 7),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end
    cmp_en = 1'b0;

    // 4-bit boundaries.
    @(negedge clk);
    s_rst_n = 1'b1;
    issue4(4'd4, 7, 0);
    chk("w4_shl_y", 32'(got4_y), 32'he);
    chk("w4_shl_cvz", 32'(got4_f), 32'b000);
    @(negedge clk);
    s_rst_n = 1'b0;
    @(negedge clk);
    s_rst_n = 1'b1;
    issue4(4'd3, 7, 1);
    chk("w4_add_y", 32'(got4_y), 32'h8);
    chk("w4_add_cvz", 32'(got4_f), 32'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
